// File: rtl/score_uart_tx_if.sv
// Score link bundle between the game logic (master) and the score UART transmitter (slave).
interface score_uart_tx_if;
  logic [3:0] player1_score;
  logic [3:0] player2_score;
  logic [1:0] state;
  logic       tx;
  logic       busy;
  logic       frame_sent;

  modport master (
    output player1_score,
    output player2_score,
    output state,
    input  tx,
    input  busy,
    input  frame_sent
  );

  modport slave (
    input  player1_score,
    input  player2_score,
    input  state,
    output tx,
    output busy,
    output frame_sent
  );
endinterface

// File: rtl/score_uart_tx.sv
// Transmit side of the inter-board score link: every score change is sent as a
// 3-byte 8N1 frame (sync, {p1,p2}, sync^{p1,p2}) followed by one idle bit time.
module score_uart_tx #(
  parameter int unsigned CLK_HZ     = 65_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter logic [1:0]  MENU_START = 2'd0
) (
  input  logic          clk,
  input  logic          rst,
  score_uart_tx_if.slave link
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } fsm_e;

  fsm_e             fsm_q,   fsm_d;
  logic [CNT_W-1:0] baud_q,  baud_d;
  logic [2:0]       bit_q,   bit_d;
  logic [1:0]       byte_q,  byte_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       score_q, score_d;
  logic [7:0]       last_q,  last_d;
  logic             tx_q,    tx_d;
  logic             busy_q,  busy_d;
  logic             sent_q,  sent_d;

  logic [7:0] snapshot;
  logic       baud_done;
  logic       resync;

  assign snapshot  = {link.player1_score, link.player2_score};
  assign baud_done = (baud_q == LAST_CNT);
  assign resync    = (link.state == MENU_START);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      score_q <= '0;
      last_q  <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      score_q <= score_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      sent_q  <= sent_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    fsm_d   = fsm_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    score_d = score_q;
    last_d  = last_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    sent_d  = 1'b0;

    unique case (fsm_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (resync) last_d = 8'hFF;
        // A snapshot capture overrides the resync clear in the same cycle.
        if (snapshot != last_q) begin
          fsm_d   = START;
          baud_d  = '0;
          byte_d  = '0;
          bit_d   = '0;
          shift_d = SYNC_BYTE;
          score_d = snapshot;
          last_d  = snapshot;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (baud_done) begin
          fsm_d  = DATA;
          baud_d = '0;
          bit_d  = '0;
          tx_d   = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            fsm_d = STOP;
            tx_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (byte_q < 2'd2) begin
            fsm_d   = START;
            byte_d  = byte_q + 1'b1;
            shift_d = (byte_q == 2'd0) ? score_q : (SYNC_BYTE ^ score_q);
            tx_d    = 1'b0;
          end else begin
            fsm_d  = GAP;
            sent_d = 1'b1;
            tx_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      GAP: begin
        tx_d = 1'b1;
        if (resync) last_d = 8'hFF;
        if (baud_done) begin
          fsm_d  = IDLE;
          baud_d = '0;
          busy_d = 1'b0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        fsm_d  = IDLE;
        baud_d = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign link.tx         = tx_q;
  assign link.busy       = busy_q;
  assign link.frame_sent = sent_q;

endmodule
